// File: rtl/reg_file.sv
// 32 x WIDTH register file: two registered read ports plus a sequential dump engine.
// Optional same-edge write forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_n,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  output logic              rvalid,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_done
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [WIDTH-1:0]  regs [DEPTH];
  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [WIDTH-1:0]  rv1, rv2, dv;

  // x0 reads as zero; forwarding (if built in) never applies to x0.
  function automatic logic [WIDTH-1:0] value(input logic [ADDR_W-1:0] a);
    if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!write_n && (waddr == a)) return wdata;
`endif
    return regs[a];
  endfunction

  always_comb begin
    rv1 = value(raddr1);
    rv2 = value(raddr2);
    dv  = value(idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      rdata1     <= '0;
      rdata2     <= '0;
      rvalid     <= 1'b0;
      state      <= IDLE;
      idx        <= '0;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      if (!write_n && (waddr != '0)) regs[waddr] <= wdata;

      rvalid <= rd_en;
      if (rd_en) begin
        rdata1 <= rv1;
        rdata2 <= rv2;
      end

      // Flags are registered from the state, so they trail it by one edge.
      case (state)
        RUN: begin
          dump_valid <= 1'b1;
          dump_addr  <= idx;
          dump_data  <= dv;
          dump_busy  <= 1'b1;
          dump_done  <= 1'b0;
          idx        <= idx + 1'b1;
          if (idx == '1) state <= DONE;
        end
        DONE: begin
          dump_valid <= 1'b0;
          dump_done  <= 1'b1;
          dump_busy  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          dump_valid <= 1'b0;
          dump_done  <= 1'b0;
          dump_busy  <= 1'b0;
          if (dump_start) begin
            state <= RUN;
            idx   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomized + directed bench for reg_file against a timeline-based behavioural model.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst, write_n, rd_en, dump_start;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata2, dump_data;
  logic [4:0]  dump_addr;
  logic        rvalid, dump_busy, dump_valid, dump_done;

  always #5 clk = ~clk;

  reg_file #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .write_n(write_n), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rvalid(rvalid),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  int n_chk = 0, n_pass = 0;
  bit check_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: register array plus a count of edges since the accepted dump_start.
  logic [31:0] mregs [32];
  logic [31:0] e_r1 = 0, e_r2 = 0, e_dd = 0;
  logic [4:0]  e_da = 0;
  logic        e_rv = 0, e_dv = 0, e_busy = 0, e_done = 0;
  bit          d_act = 0;
  int          d_e = 0;

  function automatic logic [31:0] mval(input logic [4:0] a);
    if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (!write_n && waddr == a) return wdata;
`endif
    return mregs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 0;
      e_r1 = 0; e_r2 = 0; e_rv = 0; e_dv = 0; e_da = 0; e_dd = 0;
      e_busy = 0; e_done = 0; d_act = 0; d_e = 0;
    end else begin
      e_rv = rd_en;
      if (rd_en) begin e_r1 = mval(raddr1); e_r2 = mval(raddr2); end
      if (d_act) d_e = d_e + 1;
      if (d_act && d_e >= 34) d_act = 0;
      if (dump_start && !d_act) begin d_act = 1; d_e = 0; end
      e_dv   = d_act && d_e >= 1 && d_e <= 32;
      e_busy = d_act && d_e >= 1 && d_e <= 33;
      e_done = d_act && d_e == 33;
      if (e_dv) begin e_da = 5'(d_e - 1); e_dd = mval(5'(d_e - 1)); end
      if (!write_n && waddr != 0) mregs[waddr] = wdata;
    end
  end

  always @(negedge clk) if (check_en) begin
    chk("rdata1", rdata1, e_r1);
    chk("rdata2", rdata2, e_r2);
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    chk("dump_valid", 32'(dump_valid), 32'(e_dv));
    chk("dump_addr", 32'(dump_addr), 32'(e_da));
    chk("dump_data", dump_data, e_dd);
    chk("dump_busy", 32'(dump_busy), 32'(e_busy));
    chk("dump_done", 32'(dump_done), 32'(e_done));
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_n = 0; waddr = a; wdata = d; cyc(); write_n = 1;
  endtask

  initial begin
    rst = 1; write_n = 1; waddr = 0; wdata = 0; rd_en = 0;
    raddr1 = 0; raddr2 = 0; dump_start = 0;
    cyc(); cyc();
    check_en = 1;
    chk("reset rdata1", rdata1, 0);
    chk("reset rvalid", 32'(rvalid), 0);
    chk("reset dump_busy", 32'(dump_busy), 0);
    rst = 0;

    // Reset then read
    rd_en = 1; raddr1 = 5; raddr2 = 31; cyc();
    chk("rd after rst r1", rdata1, 0);
    chk("rd after rst r2", rdata2, 0);
    chk("rvalid pulse", 32'(rvalid), 1);
    rd_en = 0; cyc();
    chk("rvalid drop", 32'(rvalid), 0);

    // Write/read, x0 discard
    wr(3, 123);
    rd_en = 1; raddr1 = 3; raddr2 = 0; cyc();
    chk("x3 read", rdata1, 123);
    chk("x0 read", rdata2, 0);
    rd_en = 0; wr(0, 546);
    rd_en = 1; raddr1 = 0; cyc();
    chk("x0 after write", rdata1, 0);
    rd_en = 0;

    // Same-edge write and read
    wr(7, 123);
    rd_en = 1; raddr1 = 7; wr(7, 546);
`ifdef REGFILE_BYPASS_EN
    chk("same-edge bypass", rdata1, 546);
`else
    chk("same-edge no bypass", rdata1, 123);
`endif
    cyc();
    chk("read after write", rdata1, 546);
    rd_en = 0;

    // Full dump with ignored mid-dump start
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 10));
    dump_start = 1; cyc(); dump_start = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      dump_start = (i == 10);
      chk("dump entry valid", 32'(dump_valid), 1);
      chk("dump entry addr", 32'(dump_addr), 32'(i));
      chk("dump entry data", dump_data, 32'(i * 10));
    end
    dump_start = 0;
    cyc();
    chk("dump_done pulse", 32'(dump_done), 1);
    chk("dump_valid in done", 32'(dump_valid), 0);
    chk("dump_busy in done", 32'(dump_busy), 1);
    cyc();
    chk("dump_done drop", 32'(dump_done), 0);
    chk("dump_busy drop", 32'(dump_busy), 0);

    // Reset mid-dump
    dump_start = 1; cyc(); dump_start = 0;
    for (int i = 0; i < 13; i++) cyc();
    chk("mid-dump addr", 32'(dump_addr), 12);
    rst = 1; cyc(); rst = 0;
    chk("abort dump_addr", 32'(dump_addr), 0);
    chk("abort dump_busy", 32'(dump_busy), 0);
    chk("abort rdata1", rdata1, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin cyc(); if (dump_done) seen++; end
      chk("no done after abort", 32'(seen), 0);
    end
    dump_start = 1; cyc(); dump_start = 0; cyc();
    chk("restart addr", 32'(dump_addr), 0);
    chk("restart valid", 32'(dump_valid), 1);
    for (int i = 0; i < 40; i++) cyc();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      write_n    = $urandom_range(0, 1);
      waddr      = 5'($urandom_range(0, 31));
      wdata      = $urandom;
      rd_en      = $urandom_range(0, 1);
      raddr1     = $urandom_range(0, 2) == 0 ? waddr : 5'($urandom_range(0, 31));
      raddr2     = $urandom_range(0, 2) == 0 ? waddr : 5'($urandom_range(0, 31));
      dump_start = ($urandom_range(0, 19) == 0);
      cyc();
    end
    rst = 0; write_n = 1; rd_en = 0; dump_start = 0;
    cyc(); cyc();
    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
